// File: rtl/rtc_reg_bank.sv
// rtc_reg_bank: bank of BCD time/date/timer registers shared with an RTC over a
// multiplexed 8-bit bus.
// Each slot has a fixed RTC address and a BCD range. The user steps the slot
// selected by Puntero with UP/DOWN, including auto-repeat while a key is held.
// Bus reads (BRes_Data) load slots that hold no pending user edit.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   BEnv_Adress   drive ADRESS onto Multiplex (highest priority)
//   BRes_Data     Multiplex carries data read from the RTC
//   BEnv_Data     drive the outbound data register onto Multiplex
//   ADRESS        current RTC address
//   Puntero       address of the slot under user edit
//   UP, DOWN      debounced user keys (level)
//   Multiplex     shared RTC data bus
//   Regs_out      stored slot values, slot i in bits [8i+7:8i]
//   Dirty         per-slot pending-user-edit flags
//   Bcd_err       one-cycle pulse on a rejected capture
module rtc_reg_bank #(
  parameter int unsigned          NREG     = 9,
  parameter logic [8*NREG-1:0]    ADDR_TAB = {8'h41, 8'h42, 8'h43, 8'h21, 8'h22, 8'h23,
                                              8'h24, 8'h25, 8'h26},
  parameter logic [8*NREG-1:0]    MAX_TAB  = {8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 8'h23,
                                              8'h31, 8'h12, 8'h99},
  parameter logic [8*NREG-1:0]    MIN_TAB  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                              8'h01, 8'h01, 8'h00},
  parameter logic [NREG-1:0]      CPL_MASK = 9'b111000000,
  parameter int unsigned          REP_DLY  = 25_000_000,
  parameter int unsigned          REP_RATE = 5_000_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BEnv_Adress,
  input  logic                BRes_Data,
  input  logic                BEnv_Data,
  input  logic [7:0]          ADRESS,
  input  logic [7:0]          Puntero,
  input  logic                UP,
  input  logic                DOWN,
  inout  wire  [7:0]          Multiplex,
  output logic [8*NREG-1:0]   Regs_out,
  output logic [NREG-1:0]     Dirty,
  output logic                Bcd_err
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [NREG-1:0][7:0] AddrA = ADDR_TAB;
  localparam logic [NREG-1:0][7:0] MaxA  = MAX_TAB;
  localparam logic [NREG-1:0][7:0] MinA  = MIN_TAB;

  typedef enum logic [1:0] {RepIdle, RepDelay, RepRate} rep_e;

  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    return (8'(v[7:4]) * 8'd10) + 8'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return {4'(b / 8'd10), 4'(b % 8'd10)};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  // ---------------------------------------------------------------------------
  // Key edge detection and auto-repeat
  // ---------------------------------------------------------------------------
  // up_low_q/dn_low_q mean "key was low last cycle" and reset to 0, so a key
  // still held through reset is not seen as a fresh press afterwards.
  logic        up_low_q, dn_low_q;
  rep_e        rep_q;
  logic [31:0] cnt_q;
  logic        step_up_q, step_dn_q;

  logic up_only, dn_only, key_rise;
  assign up_only  = UP & ~DOWN;
  assign dn_only  = DOWN & ~UP;
  assign key_rise = (up_only & up_low_q) | (dn_only & dn_low_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      up_low_q  <= 1'b0;
      dn_low_q  <= 1'b0;
      rep_q     <= RepIdle;
      cnt_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      up_low_q  <= ~UP;
      dn_low_q  <= ~DOWN;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      if (!(up_only || dn_only)) begin
        rep_q <= RepIdle;
        cnt_q <= '0;
      end else if (key_rise) begin
        // cnt_q counts cycles held, including the press cycle
        step_up_q <= up_only;
        step_dn_q <= dn_only;
        rep_q     <= RepDelay;
        cnt_q     <= 32'd1;
      end else begin
        unique case (rep_q)
          RepDelay: begin
            if (cnt_q == REP_DLY) begin
              step_up_q <= up_only;
              step_dn_q <= dn_only;
              rep_q     <= RepRate;
              cnt_q     <= 32'd1;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          RepRate: begin
            if (cnt_q == REP_RATE) begin
              step_up_q <= up_only;
              step_dn_q <= dn_only;
              cnt_q     <= 32'd1;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: cnt_q <= '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot selection (lowest index wins on duplicate addresses)
  // ---------------------------------------------------------------------------
  logic          edit_hit, addr_hit;
  logic [IW-1:0] edit_idx, addr_idx;

  always_comb begin
    edit_hit = 1'b0;
    edit_idx = '0;
    addr_hit = 1'b0;
    addr_idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (AddrA[i] == Puntero) begin
        edit_hit = 1'b1;
        edit_idx = IW'(i);
      end
      if (AddrA[i] == ADRESS) begin
        addr_hit = 1'b1;
        addr_idx = IW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot storage, dirty flags, capture and outbound data
  // ---------------------------------------------------------------------------
  logic [NREG-1:0][7:0] regs_q, regs_d;
  logic [NREG-1:0]      dirty_q, dirty_d;
  logic                 err_q, err_d;
  logic [7:0]           out_q, out_d;
  logic                 benv_q;

  logic       do_step, same_slot;
  logic [7:0] e_cur, e_max, e_min, e_new;
  logic [7:0] a_max, a_min, bus_in, bus_bin, max_bin, min_bin, val_bin;
  logic       a_cpl, digits_ok, under, cap_ok;

  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    err_d   = 1'b0;

    do_step   = (step_up_q | step_dn_q) & edit_hit;
    same_slot = do_step & addr_hit & (edit_idx == addr_idx);

    e_cur = regs_q[edit_idx];
    e_max = MaxA[edit_idx];
    e_min = MinA[edit_idx];
    if (step_up_q) begin
      e_new = (e_cur == e_max) ? e_min : bcd_inc(e_cur);
    end else begin
      e_new = (e_cur == e_min) ? e_max : bcd_dec(e_cur);
    end

    a_max   = MaxA[addr_idx];
    a_min   = MinA[addr_idx];
    a_cpl   = CPL_MASK[addr_idx];
    bus_in  = Multiplex;
    bus_bin = bcd2bin(bus_in);
    max_bin = bcd2bin(a_max);
    min_bin = bcd2bin(a_min);
    digits_ok = (bus_in[7:4] <= 4'd9) && (bus_in[3:0] <= 4'd9);
    if (a_cpl) begin
      under   = bus_bin > max_bin;
      val_bin = max_bin - bus_bin;
    end else begin
      under   = 1'b0;
      val_bin = bus_bin;
    end
    cap_ok = digits_ok && !under && (val_bin >= min_bin) && (val_bin <= max_bin);

    // Dirty clear on BEnv_Data falling edge; a step in the same cycle re-sets it below
    if (benv_q && !BEnv_Data && addr_hit) begin
      dirty_d[addr_idx] = 1'b0;
    end

    if (BRes_Data && addr_hit && !dirty_q[addr_idx] && !same_slot) begin
      if (cap_ok) begin
        regs_d[addr_idx] = bin2bcd(val_bin);
      end else begin
        err_d = 1'b1;
      end
    end

    if (do_step) begin
      regs_d[edit_idx]  = e_new;
      dirty_d[edit_idx] = 1'b1;
    end

    if (!addr_hit) begin
      out_d = 8'hFF;
    end else if (a_cpl) begin
      out_d = bin2bcd(max_bin - bcd2bin(regs_q[addr_idx]));
    end else begin
      out_d = regs_q[addr_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q  <= MinA;
      dirty_q <= '0;
      err_q   <= 1'b0;
      out_q   <= 8'hFF;
      benv_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
      out_q   <= out_d;
      benv_q  <= BEnv_Data;
    end
  end

  assign Multiplex = BEnv_Adress ? ADRESS : (BEnv_Data ? out_q : 8'hzz);
  assign Regs_out  = regs_q;
  assign Dirty     = dirty_q;
  assign Bcd_err   = err_q;

endmodule

// File: doc/rtc_reg_bank.md
RTC_REG_BANK -- requirements
Module: rtc_reg_bank

Interface
REQ-001 Parameter NREG, default 9; number of BCD register slots, 1..16.
REQ-002 Parameter ADDR_TAB, default {8'h41,8'h42,8'h43,8'h21,8'h22,8'h23,8'h24,8'h25,8'h26}; packed RTC address per slot; slot i is bits [8i+7:8i].
REQ-003 Parameter MAX_TAB, default {8'h59,8'h59,8'h23,8'h59,8'h59,8'h23,8'h31,8'h12,8'h99}; packed BCD upper bound per slot.
REQ-004 Parameter MIN_TAB, default {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'h01,8'h00}; packed BCD lower bound per slot.
REQ-005 Parameter CPL_MASK, default 9'b111000000; slots with bit set are stored as complement (MAX-x) versus bus value (timer countdown slots).
REQ-006 Parameter REP_DLY, default 25_000_000; hold cycles before auto-repeat starts. Parameter REP_RATE, default 5_000_000; cycles between repeat steps.
REQ-007 CLK  in  1  single clock; all state on rising edge.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 BEnv_Adress  in  1  drive ADRESS onto bus.
REQ-010 BRes_Data  in  1  bus carries data read from RTC.
REQ-011 BEnv_Data  in  1  drive slot data onto bus.
REQ-012 ADRESS  in  8  current RTC address.
REQ-013 Puntero  in  8  address of slot under user edit; no match = no edit.
REQ-014 UP, DOWN  in  1 each  user increment/decrement, level, already debounced.
REQ-015 Multiplex  inout  8  shared RTC data bus.
REQ-016 Regs_out  out  8*NREG  stored slot values (display view, non-complemented).
REQ-017 Dirty  out  NREG  slot edited by user, not yet written to RTC.
REQ-018 Bcd_err  out  1  one-cycle pulse on rejected capture.

Function
REQ-019 Address match: slot i selected when ADDR_TAB[i]==address; duplicate entries resolve to lowest index.
REQ-020 UP/DOWN rising edge on the edit slot SHALL step it exactly once, one cycle after the edge is sampled.
REQ-021 Held UP or DOWN: after REP_DLY cycles high, one step every REP_RATE cycles until release; release clears repeat counter.
REQ-022 UP and DOWN both high: no step; repeat counter held at 0.
REQ-023 Increment: value==MAX -> MIN, else BCD+1 (low digit 9 -> 0 with carry). Decrement: value==MIN -> MAX, else BCD-1 (low digit 0 -> 9 with borrow).
REQ-024 Any step sets Dirty[i] for the edited slot.
REQ-025 Capture: BRes_Data high, ADRESS matches slot i, Dirty[i]==0 -> slot loads bus value (MAX-bus if CPL_MASK[i]) next cycle.
REQ-026 Capture with either bus digit >9 or resulting value outside [MIN,MAX] SHALL be ignored and pulse Bcd_err.
REQ-027 Capture to a dirty slot SHALL be ignored silently (user edit protected).
REQ-028 Same-cycle step and capture on one slot: step wins.
REQ-029 Outbound data register: one cycle after ADRESS matches slot i, holds slot value (MAX-value if CPL_MASK[i]); no match -> 8'hFF.
REQ-030 Dirty[i] SHALL clear on BEnv_Data falling edge while ADRESS matches slot i; a step in that same cycle keeps Dirty[i] set.
REQ-031 Bus drive: BEnv_Adress high -> ADRESS; else BEnv_Data high -> outbound register; else high-impedance. BEnv_Adress has priority.
REQ-032 Regs_out and Dirty are registered; no combinational path from inputs.

Reset
REQ-033 RST high on a rising edge: every slot = MIN_TAB value, Dirty = 0, Bcd_err = 0, edge and repeat state = 0, outbound register = 8'hFF; bus released.
REQ-034 RST mid-repeat or mid-capture aborts the operation; no step or capture occurs in the reset cycle.

Verification
REQ-035 Puntero=8'h23, slot at 8'h23, pulse UP 24 times from reset -> 00,01..23,00; Dirty set after first pulse.
REQ-036 Puntero=8'h22, DOWN at 8'h00 -> 8'h59; hold UP REP_DLY+3*REP_RATE cycles -> exactly 4 steps total.
REQ-037 BRes_Data=1, ADRESS=8'h41, bus=8'h15 -> slot 8'h41 reads 8'h44 (59-15); bus=8'h3A -> value unchanged, Bcd_err pulse.
REQ-038 Edit slot 8'h24 to 8'h05, then capture 8'h17 at 8'h24 -> stays 8'h05; BEnv_Data 1->0 at 8'h24 -> Dirty clears, next capture 8'h17 accepted.
REQ-039 BEnv_Adress=1, ADRESS=8'h26 -> bus=8'h26; BEnv_Data=1, ADRESS=8'h10 -> bus=8'hFF; both low -> bus Z.
REQ-040 RST during held UP repeat -> all slots at MIN, no further steps until a new UP rising edge.
